// File: rtl/jk_excitation_driver_if.sv
// ---------------------------------------------------------------------------
// jk_excitation_driver_if
//   Bundle between a target-word source, the JK excitation driver and the
//   external JK flop bank that the driver controls.
//
//   Signals:
//     tgt_valid / tgt_data / tgt_ready : target-word valid/ready handshake
//     q_fb                             : Q outputs of the external flops
//     j / k                            : excitation applied to the flops
//
//   Modports:
//     slave  : the driver (consumes targets and feedback, drives j/k)
//     master : the environment (target source plus the flop bank)
// ---------------------------------------------------------------------------
interface jk_excitation_driver_if #(
    parameter int WIDTH = 4
) ();
    logic             tgt_valid;
    logic [WIDTH-1:0] tgt_data;
    logic             tgt_ready;
    logic [WIDTH-1:0] q_fb;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;

    modport slave (
        input  tgt_valid, tgt_data, q_fb,
        output tgt_ready, j, k
    );

    modport master (
        output tgt_valid, tgt_data, q_fb,
        input  tgt_ready, j, k
    );
endinterface

// File: rtl/jk_excitation_driver.sv
// ---------------------------------------------------------------------------
// jk_excitation_driver
//   Closed-loop driver for a bank of external JK flops. A target word is
//   accepted on a valid/ready handshake, the J/K excitation is derived from
//   the current flop outputs and applied for one clock, and after one
//   settle cycle the flop outputs are compared with the target. Every
//   transaction ends with a one-cycle done pulse; mismatches set a sticky
//   err flag and bump a saturating 8-bit counter.
//
//   Ports:
//     clk      : rising-edge clock, shared with the external flops
//     rst_n    : asynchronous active-low reset
//     err_clr  : synchronous clear of err / err_cnt (wins over a mismatch)
//     bus      : jk_excitation_driver_if.slave (handshake, q_fb, j, k)
//     done     : one-cycle completion pulse
//     err      : sticky mismatch flag
//     err_cnt  : mismatch count, saturating at 255
//
//   Build option:
//     JK_TOGGLE_EN : when defined, every bit that has to change is driven
//                    with J=K=1 (toggle) instead of a set/reset pair.
// ---------------------------------------------------------------------------
module jk_excitation_driver #(
    parameter int WIDTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     err_clr,
    jk_excitation_driver_if.slave    bus,
    output logic                     done,
    output logic                     err,
    output logic [7:0]               err_cnt
);

    typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, CHECK} state_t;

    state_t           state, state_n;
    logic [WIDTH-1:0] tgt_q, tgt_n;
    logic [WIDTH-1:0] j_q, j_n, k_q, k_n;
    logic             rdy_q, rdy_n;
    logic             done_n, err_n;
    logic [7:0]       cnt_n;

    // Excitation from the live feedback and the offered target word.
    logic [WIDTH-1:0] jx, kx;
`ifdef JK_TOGGLE_EN
    assign jx = bus.tgt_data ^ bus.q_fb;
    assign kx = bus.tgt_data ^ bus.q_fb;
`else
    assign jx = bus.tgt_data & ~bus.q_fb;
    assign kx = ~bus.tgt_data & bus.q_fb;
`endif

    assign bus.j         = j_q;
    assign bus.k         = k_q;
    assign bus.tgt_ready = rdy_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            tgt_q   <= '0;
            j_q     <= '0;
            k_q     <= '0;
            rdy_q   <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            err_cnt <= 8'd0;
        end else begin
            state   <= state_n;
            tgt_q   <= tgt_n;
            j_q     <= j_n;
            k_q     <= k_n;
            rdy_q   <= rdy_n;
            done    <= done_n;
            err     <= err_n;
            err_cnt <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        tgt_n   = tgt_q;
        j_n     = j_q;
        k_n     = k_q;
        rdy_n   = rdy_q;
        done_n  = 1'b0;
        err_n   = err;
        cnt_n   = err_cnt;

        case (state)
            IDLE: begin
                // Ready rises one edge after reset release; a valid seen
                // while ready is still low is left for the source to hold.
                if (!rdy_q) begin
                    rdy_n = 1'b1;
                end else if (bus.tgt_valid) begin
                    tgt_n   = bus.tgt_data;
                    j_n     = jx;
                    k_n     = kx;
                    rdy_n   = 1'b0;
                    state_n = DRIVE;
                end
            end
            DRIVE: begin
                // Flops sample j/k on this edge; release them afterwards.
                j_n     = '0;
                k_n     = '0;
                state_n = SETTLE;
            end
            SETTLE: begin
                state_n = CHECK;
            end
            CHECK: begin
                if (bus.q_fb != tgt_q) begin
                    err_n = 1'b1;
                    if (err_cnt != 8'hff)
                        cnt_n = err_cnt + 8'd1;
                end
                done_n  = 1'b1;
                rdy_n   = 1'b1;
                state_n = IDLE;
            end
            default: begin
                j_n     = '0;
                k_n     = '0;
                state_n = IDLE;
            end
        endcase

        if (err_clr) begin
            err_n = 1'b0;
            cnt_n = 8'd0;
        end
    end

endmodule

// File: tb/tb_jk_excitation_driver.sv
// ---------------------------------------------------------------------------
// tb_jk_excitation_driver
//   Drives jk_excitation_driver against a behavioural JK flop bank. The bank
//   can be frozen with its outputs stuck at zero to force mismatches. The
//   reference tracks the intended bank contents, the expected excitation,
//   and the expected err / err_cnt with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_jk_excitation_driver;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic err_clr = 1'b0;
    logic done, err;
    logic [7:0] err_cnt;

    jk_excitation_driver_if #(.WIDTH(W)) bus ();

    jk_excitation_driver #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .err_clr (err_clr),
        .bus     (bus),
        .done    (done),
        .err     (err),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural JK flop bank; frozen and reading zero while stuck.
    logic [W-1:0] bank = '0;
    logic         stuck = 1'b0;
    assign bus.q_fb = stuck ? '0 : bank;

    always @(posedge clk) begin
        if (!stuck) begin
            for (int b = 0; b < W; b++) begin
                case ({bus.j[b], bus.k[b]})
                    2'b10:   bank[b] <= 1'b1;
                    2'b01:   bank[b] <= 1'b0;
                    2'b11:   bank[b] <= ~bank[b];
                    default: bank[b] <= bank[b];
                endcase
            end
        end
    end

    int nchk = 0;
    int nerr = 0;

    // Reference state
    logic [W-1:0] ref_bank = '0;
    logic         ref_err  = 1'b0;
    int           ref_cnt  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic void excite(input logic [W-1:0] t, input logic [W-1:0] q,
                                   output logic [W-1:0] ej, output logic [W-1:0] ek);
        for (int b = 0; b < W; b++) begin
            ej[b] = 1'b0;
            ek[b] = 1'b0;
            if (t[b] != q[b]) begin
`ifdef JK_TOGGLE_EN
                ej[b] = 1'b1;
                ek[b] = 1'b1;
`else
                if (t[b]) ej[b] = 1'b1;
                else      ek[b] = 1'b1;
`endif
            end
        end
    endfunction

    // One full transaction: wait for ready, offer t, follow E0..E3.
    task automatic do_txn(input logic [W-1:0] t, input bit stk, input bit clr,
                          output logic [W-1:0] jc, output logic [W-1:0] kc);
        int n;
        logic [W-1:0] qv, ej, ek, qexp;
        stuck = stk;
        n = 0;
        @(negedge clk);
        while (!bus.tgt_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", (n < 20), 1);
        qv = stk ? '0 : ref_bank;
        excite(t, qv, ej, ek);
        bus.tgt_valid = 1'b1;
        bus.tgt_data  = t;
        @(posedge clk); #1;                         // E0
        jc = bus.j;
        kc = bus.k;
        chk("drive_j", bus.j, ej);
        chk("drive_k", bus.k, ek);
        chk("drive_jk_excl", ((bus.j & bus.k) != 0),
`ifdef JK_TOGGLE_EN
            ((ej & ek) != 0));
`else
            0);
`endif
        chk("e0_ready", bus.tgt_ready, 0);
        chk("e0_done", done, 0);
        bus.tgt_valid = 1'b0;
        bus.tgt_data  = W'($urandom);
        @(posedge clk); #1;                         // E1
        chk("e1_j", bus.j, 0);
        chk("e1_k", bus.k, 0);
        chk("e1_done", done, 0);
        @(posedge clk); #1;                         // E2
        chk("e2_done", done, 0);
        chk("e2_ready", bus.tgt_ready, 0);
        if (clr) err_clr = 1'b1;
        @(posedge clk); #1;                         // E3
        err_clr = 1'b0;
        qexp = stk ? '0 : t;
        if (!stk) ref_bank = t;
        if (clr) begin
            ref_err = 1'b0;
            ref_cnt = 0;
        end else if (qexp != t) begin
            ref_err = 1'b1;
            if (ref_cnt < 255) ref_cnt++;
        end
        chk("e3_done", done, 1);
        chk("e3_ready", bus.tgt_ready, 1);
        chk("e3_qfb", bus.q_fb, qexp);
        chk("e3_err", err, ref_err);
        chk("e3_err_cnt", err_cnt, ref_cnt);
    endtask

    initial begin
        logic [W-1:0] jc, kc;
        int n;
        bus.tgt_valid = 1'b1;
        bus.tgt_data  = 4'b1010;

        // Reset held with a valid target offered
        repeat (3) @(posedge clk);
        #1;
        chk("rst_j", bus.j, 0);
        chk("rst_k", bus.k, 0);
        chk("rst_ready", bus.tgt_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_cnt", err_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rel_ready", bus.tgt_ready, 1);
        chk("rel_no_accept_j", bus.j, 0);

        // 0000 -> 1010, then 1010 -> 0110
        do_txn(4'b1010, 0, 0, jc, kc);
        chk("t1_j", jc, 4'b1010);
        chk("t1_k", kc, 4'b0000);
        do_txn(4'b0110, 0, 0, jc, kc);
`ifdef JK_TOGGLE_EN
        chk("t2_j", jc, 4'b1100);
        chk("t2_k", kc, 4'b1100);
`else
        chk("t2_j", jc, 4'b0100);
        chk("t2_k", kc, 4'b1000);
`endif

        // Reset during DRIVE
        do_txn(4'b0000, 0, 0, jc, kc);
        @(negedge clk);
        n = 0;
        while (!bus.tgt_ready && n < 20) begin @(negedge clk); n++; end
        bus.tgt_valid = 1'b1;
        bus.tgt_data  = 4'b0011;
        @(posedge clk); #1;
        chk("mid_j", bus.j, 4'b0011);
        bus.tgt_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_j", bus.j, 0);
        chk("mid_rst_k", bus.k, 0);
        chk("mid_rst_ready", bus.tgt_ready, 0);
        ref_err = 1'b0;
        ref_cnt = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            chk("mid_rst_done", done, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("mid_rel_ready", bus.tgt_ready, 1);
        chk("mid_rel_done", done, 0);
        chk("mid_bank", bus.q_fb, ref_bank);
        do_txn(4'b0101, 0, 0, jc, kc);

        // Stuck bank: mismatch count and saturation
        for (int i = 0; i < 300; i++) do_txn(4'b1111, 1, 0, jc, kc);
        chk("sat_cnt", err_cnt, 255);

        // Standalone clear, five mismatches, then clear against a mismatch
        @(negedge clk);
        err_clr = 1'b1;
        @(posedge clk); #1;
        err_clr = 1'b0;
        ref_err = 1'b0;
        ref_cnt = 0;
        chk("clr_err", err, 0);
        chk("clr_cnt", err_cnt, 0);
        for (int i = 0; i < 5; i++) do_txn(4'b1111, 1, 0, jc, kc);
        chk("five_cnt", err_cnt, 5);
        do_txn(4'b1111, 1, 1, jc, kc);
        chk("clr_wins_cnt", err_cnt, 0);
        chk("clr_wins_err", err, 0);

        // Randomized transactions
        for (int i = 0; i < 80; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            do_txn(W'($urandom), ($urandom % 8) == 0, ($urandom % 8) == 0, jc, kc);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/jk_excitation_driver.md
# jk_excitation_driver

Closed-loop driver for a bank of external JK flip-flops. It accepts a target state word on a valid/ready handshake, computes the J/K excitation from the current flop outputs, and applies it for exactly one clock. It then checks that the flops reached the target and reports completion and mismatches. It is the driving end of the JK flip-flop interface and replaces hand-written stimulus tasks for JK register banks in both RTL and benches.

## Interface
- WIDTH, 4: number of JK flops driven (1..32)
- clk  input  1  rising-edge clock, shared with the external JK flops
- rst_n  input  1  reset; asynchronous, active-low
- tgt_valid  input  1  target word valid
- tgt_data  input  WIDTH  desired next state of the flop bank
- tgt_ready  output  1  driver can accept a target (registered)
- q_fb  input  WIDTH  Q outputs of the external JK flops
- err_clr  input  1  synchronous clear of err and err_cnt
- j  output  WIDTH  J inputs to the flops (registered)
- k  output  WIDTH  K inputs to the flops (registered)
- done  output  1  one-cycle pulse when a transaction completes
- err  output  1  sticky flag; set on any check mismatch
- err_cnt  output  8  mismatch count; saturates at 255

## Operation
- Reset values (all applied asynchronously while rst_n=0): state=IDLE, j=0, k=0, tgt_ready=0, done=0, err=0, err_cnt=0, latched target=0.
- FSM states: IDLE, DRIVE, SETTLE, CHECK.
- IDLE:
  - If tgt_ready=0, set tgt_ready←1 (first edge after reset release).
  - If tgt_valid&tgt_ready: latch tgt_data as T, set j/k←excitation(q_fb, T), set tgt_ready←0, go to DRIVE.
  - tgt_valid with tgt_ready=0 is ignored; the source holds data until accepted.
- DRIVE: set j←0, k←0, go to SETTLE. The external flops sample j/k on this edge.
- SETTLE: go to CHECK. This is a one-cycle margin for q_fb to propagate.
- CHECK:
  - Compare q_fb with T.
  - On mismatch: err←1, err_cnt←err_cnt+1 (held at 255).
  - Set done←1, tgt_ready←1, go to IDLE.
- done is 0 in every cycle other than the one following the CHECK edge.
- Excitation per bit (default): J=T&~Q, K=~T&Q. A bit that is already at its target gets J=K=0 (hold).
- err_clr (sampled every edge) forces err←0 and err_cnt←0. If it coincides with a CHECK mismatch, the clear wins.
- Reset mid-operation: the transaction is dropped, j/k drop to 0 immediately, and no done is issued.

## Timing
- Accept edge E0: j/k are valid from E0 to E1.
- E1: the external flops update; j/k return to 0.
- E2: state moves to CHECK.
- E3: compare. done is high and tgt_ready is high in cycle E3–E4.
- The next accept can occur at E4, giving one transaction per 4 cycles.
- Latency from accept to done is 3 cycles.
- j and k are never both 1 in default mode.
- tgt_ready is low from E0 until the E3 edge.

## Configuration
- JK_TOGGLE_EN defined: any bit with Q≠T gets J=K=1 (toggle), and bits with Q=T get J=K=0. This exercises the toggle path of the flops.
- JK_TOGGLE_EN undefined: the set/reset excitation above is used, and J=K=1 never occurs.
- The CHECK semantics are identical in both modes.

## Test plan
- Reset: hold rst_n=0 with tgt_valid=1 → j=k=0, tgt_ready=0, done=0, err=0, err_cnt=0. First edge after release → tgt_ready=1; the next edge accepts the target.
- With a behavioral JK flop model, q_fb=0000, target 1010 → during DRIVE j=1010, k=0000. done pulses 3 cycles after accept, q_fb=1010, err=0.
- From q_fb=1010, target 0110 → j=0100, k=1000 in default mode. With JK_TOGGLE_EN, j=k=1100. Both modes end with q_fb=0110 and err=0.
- Flop model stuck at 0000, target 1111 → err=1, err_cnt=1. After 300 such transactions err_cnt=255 (saturated).
- Assert err_clr in the same cycle as a mismatching CHECK with err_cnt=5 → err=0, err_cnt=0 after the edge.
- Drop rst_n during DRIVE with j=0011 → j=k=0 asynchronously, no done pulse. After release, tgt_ready=1 on the first edge and a new target completes normally.
